// File: rtl/led7_scan_decoder.sv
//==============================================================================
// led7_scan_decoder: recovers HH:MM from a multiplexed active-low 7-segment
// bus and publishes it after repeated identical, range-valid frames.
// Revision: 1.0
//==============================================================================
`default_nettype none

module led7_scan_decoder #(
  parameter int STABLE_CYC  = 4,
  parameter int CONFIRM_FR  = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] led7_seg_i,
  input  logic [7:0] led7_an_i,
  output logic [1:0] hr2_o,
  output logic [3:0] hr1_o,
  output logic [3:0] min2_o,
  output logic [3:0] min1_o,
  output logic       kropka_o,
  output logic       time_valid_o,
  output logic       time_upd_o,
  output logic       seg_err_o,
  output logic       stale_o
);

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int CW = $clog2(CONFIRM_FR + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [SW-1:0] C_STAB_MAX = SW'(STABLE_CYC);
  localparam logic [CW-1:0] C_CONF_MAX = CW'(CONFIRM_FR);
  localparam logic [TW-1:0] C_TMO_MAX  = TW'(TIMEOUT_CYC);

  typedef enum logic [0:0] {
    ST_SCAN = 1'b0,
    ST_EVAL = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Input sampling and stability tracking
  logic [7:0]    seg_q, an_q;
  logic [15:0]   prev_q;
  logic [SW-1:0] stab_q, stab_d;

  // Frame under assembly
  logic [3:0]       mask_q, mask_d;
  logic [3:0][3:0]  slot_q, slot_d;
  logic             dp_q, dp_d;
  logic             derr_q, derr_d;

  // Confirmation / published state
  logic [16:0]   last_q, last_d;
  logic [CW-1:0] conf_q, conf_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          seen_q, seen_d;
  logic [1:0]    hr2_q, hr2_d;
  logic [3:0]    hr1_q, hr1_d;
  logic [3:0]    min2_q, min2_d;
  logic [3:0]    min1_q, min1_d;
  logic          kropka_q, kropka_d;
  logic          valid_q, valid_d;
  logic          upd_q, upd_d;
  logic          err_q, err_d;
  logic          stale_q, stale_d;

  logic [15:0] w_sample;
  logic        w_an_ok;
  logic [1:0]  w_idx;
  logic        w_same;
  logic        w_cap;
  logic [3:0]  w_dec_val;
  logic        w_dec_bad;
  logic        w_bad;
  logic        w_good;
  logic [16:0] w_frame;
  logic [16:0] w_out;

  assign w_sample = {an_q, seg_q};
  assign w_same   = (w_sample == prev_q);

  always_comb begin
    w_an_ok = (an_q[7:4] == 4'hF);
    w_idx   = 2'd0;
    case (an_q[3:0])
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_an_ok = 1'b0;
    endcase
  end

  always_comb begin
    stab_d = stab_q;
    if (!w_an_ok) begin
      stab_d = '0;
    end else if (w_same) begin
      if (stab_q != C_STAB_MAX) stab_d = stab_q + SW'(1);
    end else begin
      stab_d = SW'(1);
    end
  end

  // One capture per dwell: the counter saturates, so only its arrival counts
  assign w_cap = w_an_ok && (stab_d == C_STAB_MAX) && !(w_same && (stab_q == C_STAB_MAX));

  always_comb begin
    w_dec_val = 4'd0;
    w_dec_bad = 1'b0;
    case (seg_q[6:0])
      7'h40: w_dec_val = 4'd0;
      7'h79: w_dec_val = 4'd1;
      7'h24: w_dec_val = 4'd2;
      7'h30: w_dec_val = 4'd3;
      7'h19: w_dec_val = 4'd4;
      7'h12: w_dec_val = 4'd5;
      7'h02: w_dec_val = 4'd6;
      7'h78: w_dec_val = 4'd7;
      7'h00: w_dec_val = 4'd8;
      7'h10: w_dec_val = 4'd9;
      7'h7F: w_dec_bad = (w_idx != 2'd3);
      default: w_dec_bad = 1'b1;
    endcase
  end

  assign w_frame = {dp_q, slot_q};
  assign w_out   = {kropka_q, 2'b00, hr2_q, hr1_q, min2_q, min1_q};
  assign w_bad   = derr_q
                 || (slot_q[3] > 4'd2)
                 || ((slot_q[3] == 4'd2) && (slot_q[2] > 4'd3))
                 || (slot_q[1] > 4'd5);
  assign w_good  = (state_q == ST_EVAL) && !w_bad;

  // Frame assembly and FSM
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    dp_d    = dp_q;
    mask_d  = mask_q;
    derr_d  = derr_q;
    if (state_q == ST_EVAL) begin
      mask_d  = 4'b0000;
      derr_d  = 1'b0;
      state_d = ST_SCAN;
    end
    if (w_cap) begin
      slot_d[w_idx] = w_dec_val;
      mask_d[w_idx] = 1'b1;
      if (w_dec_bad) derr_d = 1'b1;
      if (w_idx == 2'd2) dp_d = ~seg_q[7];
    end
    if ((state_q == ST_SCAN) && (mask_d == 4'b1111)) state_d = ST_EVAL;
  end

  // Frame evaluation, confirmation and timeout
  always_comb begin
    last_d   = last_q;
    conf_d   = conf_q;
    tmo_d    = tmo_q;
    seen_d   = seen_q;
    hr2_d    = hr2_q;
    hr1_d    = hr1_q;
    min2_d   = min2_q;
    min1_d   = min1_q;
    kropka_d = kropka_q;
    valid_d  = valid_q;
    upd_d    = 1'b0;
    err_d    = err_q;
    stale_d  = stale_q;

    if (w_good) begin
      err_d   = 1'b0;
      tmo_d   = '0;
      stale_d = 1'b0;
      last_d  = w_frame;
      if (w_frame == last_q) begin
        if (conf_q != C_CONF_MAX) conf_d = conf_q + CW'(1);
      end else begin
        conf_d = CW'(1);
      end
      if (conf_d == C_CONF_MAX) begin
        valid_d = 1'b1;
        seen_d  = 1'b1;
        // After a stale period an unchanged time is re-validated silently
        if ((w_frame != w_out) || !seen_q) begin
          hr2_d    = slot_q[3][1:0];
          hr1_d    = slot_q[2];
          min2_d   = slot_q[1];
          min1_d   = slot_q[0];
          kropka_d = dp_q;
          upd_d    = 1'b1;
        end
      end
    end else begin
      if (state_q == ST_EVAL) begin
        err_d  = 1'b1;
        conf_d = '0;
      end
      if (tmo_q != C_TMO_MAX) tmo_d = tmo_q + TW'(1);
      if (tmo_d == C_TMO_MAX) begin
        stale_d = 1'b1;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_SCAN;
      seg_q    <= '0;
      an_q     <= '0;
      prev_q   <= '0;
      stab_q   <= '0;
      mask_q   <= '0;
      slot_q   <= '0;
      dp_q     <= 1'b0;
      derr_q   <= 1'b0;
      last_q   <= '0;
      conf_q   <= '0;
      tmo_q    <= '0;
      seen_q   <= 1'b0;
      hr2_q    <= '0;
      hr1_q    <= '0;
      min2_q   <= '0;
      min1_q   <= '0;
      kropka_q <= 1'b0;
      valid_q  <= 1'b0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
      stale_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      seg_q    <= led7_seg_i;
      an_q     <= led7_an_i;
      prev_q   <= w_sample;
      stab_q   <= stab_d;
      mask_q   <= mask_d;
      slot_q   <= slot_d;
      dp_q     <= dp_d;
      derr_q   <= derr_d;
      last_q   <= last_d;
      conf_q   <= conf_d;
      tmo_q    <= tmo_d;
      seen_q   <= seen_d;
      hr2_q    <= hr2_d;
      hr1_q    <= hr1_d;
      min2_q   <= min2_d;
      min1_q   <= min1_d;
      kropka_q <= kropka_d;
      valid_q  <= valid_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
      stale_q  <= stale_d;
    end
  end

  assign hr2_o        = hr2_q;
  assign hr1_o        = hr1_q;
  assign min2_o       = min2_q;
  assign min1_o       = min1_q;
  assign kropka_o     = kropka_q;
  assign time_valid_o = valid_q;
  assign time_upd_o   = upd_q;
  assign seg_err_o    = err_q;
  assign stale_o      = stale_q;

endmodule

`default_nettype wire

// File: doc/led7_scan_decoder.md
Name: led7_scan_decoder

Overview:
- Receive-side counterpart of the clock's multiplexed 7-segment driver.
- Samples the scanned segment/anode bus and decodes each digit back to BCD.
- Assembles full HH:MM frames and publishes the time only after consecutive identical, range-valid frames.
- Used as an on-chip self-check of the displayed time and as a bench monitor for the display path.

Parameters:
STABLE_CYC, 4, consecutive identical samples (anode+segments) required before a digit is captured
CONFIRM_FR, 2, consecutive identical valid frames required before outputs update
TIMEOUT_CYC, 1000, cycles without a valid frame before stale_o asserts (sim scale; board 400000)

Ports:
clk_i  input  1  system clock, 100 MHz
rst_i  input  1  asynchronous reset, active-low
led7_seg_i  input  8  segments, active-low; bit0=a..bit6=g, bit7=dp
led7_an_i  input  8  anodes, active-low; an[0]=min ones, an[1]=min tens, an[2]=hr ones, an[3]=hr tens
hr2_o  output  2  hours tens (0..2)
hr1_o  output  4  hours ones (0..9)
min2_o  output  4  minutes tens (0..5)
min1_o  output  4  minutes ones (0..9)
kropka_o  output  1  dp state captured on digit 2 (seconds blink)
time_valid_o  output  1  level: outputs hold a confirmed time
time_upd_o  output  1  one-cycle pulse when outputs change
seg_err_o  output  1  high from a bad frame until the next good frame
stale_o  output  1  no valid frame within TIMEOUT_CYC

Behaviour:
- Reset (rst_i=0, async): all outputs 0, all internal counters, masks and capture registers cleared, FSM=SCAN. No output activity until release.
- Inputs are registered once (1-cycle latency) before use.
- Anode qualification:
  - Exactly one of an[3:0] low and an[7:4] all high -> digit index 0..3.
  - Any other pattern (none, multiple, upper anode active) -> sample ignored; stability counter reset.
- Stability: counter increments while {an,seg} equals the previous sample and resets to 1 on any change. The digit is captured exactly once per dwell, on the cycle the counter reaches STABLE_CYC.
- Segment decode (seg[6:0], active-low):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - 0x7F (blank) decodes to 0 on digit 3 only.
  - Any other pattern marks the frame bad.
- Capture: decoded value written into the digit slot and its mask bit set. dp captured only on digit 2. A re-capture of an already-masked digit overwrites it.
- FSM:
  - SCAN: capture as above. When mask==4'b1111 -> EVAL next cycle.
  - EVAL (1 cycle): check the frame, clear mask, return to SCAN. A capture arriving in the EVAL cycle is applied to the new frame.
- Frame check in EVAL:
  - Bad if any decode error, hr2>2, hr2==2 && hr1>3, or min2>5.
  - Bad frame: seg_err_o=1, confirm counter=0, outputs unchanged, timeout not cleared.
  - Good frame: seg_err_o=0, timeout counter=0, stale_o=0.
    - If equal to the previous good frame: confirm counter increments, saturating at CONFIRM_FR.
    - Otherwise: confirm counter=1.
    - When the counter reaches CONFIRM_FR and the frame differs from the current outputs (digits or kropka): update outputs, time_valid_o=1, time_upd_o pulses for 1 cycle.
- Output latency: last digit capture -> time_upd_o = 1 cycle (the EVAL cycle) plus the input register.
- Timeout: counter increments every cycle and saturates at TIMEOUT_CYC. On reaching it: stale_o=1, time_valid_o=0, digit outputs hold their last values. The next confirmed good frame clears stale_o and sets time_valid_o even if the digits are unchanged, with no time_upd_o pulse.
- Simultaneous timeout expiry and good frame in the same cycle: good frame wins, stale_o stays 0.
- Reset mid-frame: partial mask discarded; the first frame after reset needs CONFIRM_FR full frames.

Test Plan:
- Scan "12:34", dp=1, 25-cycle dwell per digit, 3 frames -> after 2nd frame EVAL: hr2=1, hr1=2, min2=3, min1=4, kropka=1, time_valid_o=1, one time_upd_o pulse; 3rd frame produces no pulse.
- Frames "12:34","12:35","12:35" -> no update after frame 2; update to min1=5 after frame 3.
- Digit 1 driven with seg 0x7F, and separately "25:00" -> seg_err_o=1, outputs hold "12:35"; next good frame -> seg_err_o=0.
- Anodes 4'b1100 (two digits active) for 30 cycles mid-frame -> no capture, no error; frame completes normally afterward.
- Glitchy dwell: seg changes every 3 cycles with STABLE_CYC=4 -> no capture; stop scanning for 1000 cycles -> stale_o=1, time_valid_o=0; resume "12:35" x2 -> stale_o=0, time_valid_o=1, no time_upd_o.
- Assert rst_i=0 after 3 digits captured -> all outputs 0 asynchronously; release and scan "00:00" x2 -> time_valid_o=1, digits 0, time_upd_o pulses once (kropka/valid change).
